// File: rtl/run_ctrl_pkg.sv
// Shared types and limits for the run_ctrl test-run controller.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_CHANNELS = 32;

endpackage

// File: rtl/run_ctrl_wdog.sv
// Single-channel watchdog: counts consecutive beat-less RUN cycles and latches
// a fail flag on the TIMEOUT-th one; a beat in that same cycle wins.
module run_wdog #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    input  logic beat_i,
    output logic fail_o,
    output logic fail_d_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fail_q, fail_d;

    // Once failed the counter stops advancing, so it can never wrap.
    always_comb begin
        cnt_d  = cnt_q;
        fail_d = fail_q;
        if (clear_i) begin
            cnt_d  = '0;
            fail_d = 1'b0;
        end else if (run_i) begin
            if (beat_i) begin
                cnt_d = '0;
            end else if (!fail_q) begin
                if (cnt_q == LAST) begin
                    fail_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            fail_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fail_q <= fail_d;
        end
    end

    assign fail_o   = fail_q;
    assign fail_d_o = fail_d;

endmodule

// File: rtl/run_ctrl.sv
// Fixed-duration run controller with sticky per-channel fail capture and verdict.
// Per-channel watchdogs are built only when RUN_CTRL_WDOG_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int DURATION = 100000,
    parameter int CHANNELS = 4,
    parameter int TIMEOUT  = 1000,
    parameter int CW       = $clog2(DURATION + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CHANNELS-1:0] beat_i,
    input  logic [CHANNELS-1:0] err_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                pass_o,
    output logic [CHANNELS-1:0] fail_mask_o,
    output logic [CW-1:0]       elapsed_o
);

    generate
        if (DURATION < 2 || TIMEOUT < 1 || CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_params
            $error("run_ctrl: illegal DURATION/TIMEOUT/CHANNELS");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_EL = CW'(DURATION - 1);

    state_e              state_q;
    logic                busy_q, done_q, pass_q;
    logic [CW-1:0]       elapsed_q;
    logic [CHANNELS-1:0] err_mask_q, err_mask_d;
    logic [CHANNELS-1:0] wdog_fail_q, wdog_fail_d;
    logic                in_run, last_cyc;

    assign in_run     = (state_q == ST_RUN);
    assign last_cyc   = in_run && (elapsed_q == LAST_EL);
    assign err_mask_d = err_mask_q | err_i;

`ifdef RUN_CTRL_WDOG_EN
    logic start_acc;
    assign start_acc = start_i && !in_run;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_wdog
        run_wdog #(
            .TIMEOUT (TIMEOUT)
        ) u_wdog (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (start_acc),
            .run_i    (in_run),
            .beat_i   (beat_i[ch]),
            .fail_o   (wdog_fail_q[ch]),
            .fail_d_o (wdog_fail_d[ch])
        );
    end
`else
    logic unused_beat;
    assign unused_beat = ^beat_i;
    assign wdog_fail_q = '0;
    assign wdog_fail_d = '0;
`endif

    // Verdict uses next-cycle fail state so errors in the final cycle count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            elapsed_q  <= '0;
            err_mask_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        pass_q     <= 1'b0;
                        elapsed_q  <= '0;
                        err_mask_q <= '0;
                    end
                end
                ST_RUN: begin
                    elapsed_q  <= elapsed_q + CW'(1);
                    err_mask_q <= err_mask_d;
                    if (abort_i || last_cyc) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= !abort_i && ((err_mask_d | wdog_fail_d) == '0);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign elapsed_o   = elapsed_q;
    assign fail_mask_o = err_mask_q | wdog_fail_q;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Parametrised test-run controller: times a run of fixed cycle duration, supervises up to CHANNELS activity sources with per-channel watchdogs and sticky error capture, and reports done/pass with a per-channel fail mask. It is the synthesizable successor to the bench-only fixed-duration run loop. It is instantiated in benches as the run/verdict authority and on the board to drive status LEDs.

## Interface
- DURATION, 100000: run length in clk cycles; must be ≥ 2.
- CHANNELS, 4: number of supervised channels, 1..32.
- TIMEOUT, 1000: maximum consecutive beat-less RUN cycles per channel; must be ≥ 1.
- CW, $clog2(DURATION+1): derived elapsed-counter width; not overridden.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start_i  in  1  begin a run; acted on in IDLE or DONE only.
- abort_i  in  1  end the current run as failed; sampled in RUN only.
- beat_i  in  CHANNELS  per-channel activity pulse; clears that channel's watchdog.
- err_i  in  CHANNELS  per-channel error pulse; sets that channel's sticky fail bit.
- busy_o  out  1  high in RUN.
- done_o  out  1  high in DONE.
- pass_o  out  1  verdict; valid only while done_o is high, otherwise 0.
- fail_mask_o  out  CHANNELS  sticky per-channel fail bits.
- elapsed_o  out  CW  count of completed RUN cycles.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start_i. Entry clears elapsed, fail mask, watchdogs and the abort flag.
- RUN → DONE when elapsed_o == DURATION-1 in the current cycle, or when abort_i is asserted.
- DONE → RUN on start_i (restart; same clears as from IDLE). Otherwise DONE holds indefinitely.
- start_i in RUN is ignored.
- elapsed_o increments by 1 every RUN cycle, including the final and abort cycles. It freezes in DONE: DURATION after a full run, k+1 when abort is sampled at elapsed k. It cannot wrap.
- Watchdog, per channel:
  - The counter counts consecutive RUN cycles with no beat. A beat clears it.
  - On the TIMEOUT-th consecutive beat-less cycle, the channel's fail bit sets.
  - A beat in that same cycle wins: the counter clears and no fail is recorded.
  - Once a channel has failed, its counter saturates.
- err_i sets the fail bit in any RUN cycle, including the final one.
- Fail bits are sticky until the next run start or reset.
- pass_o = (fail_mask_o == 0) && !aborted. It is registered on entry to DONE.
- If abort_i coincides with the final cycle, abort wins and pass_o = 0.
- beat_i, err_i and abort_i are ignored outside RUN.
- Reset values: state IDLE; busy_o, done_o, pass_o = 0; fail_mask_o = 0; elapsed_o = 0.

## Timing
- start_i high at edge t (IDLE/DONE) → busy_o = 1 and elapsed_o = 0 after t. done_o drops in the same cycle.
- A full run holds busy_o for exactly DURATION cycles; done_o and pass_o rise in the following cycle.
- Abort sampled at edge a → done_o = 1 after a; busy_o = 0 in the same cycle.
- Fail bit from err_i or timeout is visible one cycle after the causing RUN cycle.
- Channel with no beats from run start → fail bit visible TIMEOUT+1 cycles after start is accepted.
- rst_n assertion clears all outputs immediately, asynchronously, including mid-run. Deassertion is synchronised externally.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- RUN_CTRL_WDOG_EN defined: per-channel watchdogs are built as described.
- RUN_CTRL_WDOG_EN undefined:
  - No watchdog logic is instantiated; beat_i is unused.
  - Fail bits are set only by err_i.
  - Timing of all other behaviour is unchanged.

## Structure
- Package run_ctrl_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - a shared constant for the maximum CHANNELS (32).
- Sub-module run_wdog: one channel's watchdog (counter, beat clear, saturating fail flag), parameter TIMEOUT.
  - Generated CHANNELS times, inside the RUN_CTRL_WDOG_EN guard.
- Top holds the FSM, elapsed counter, sticky fail/err merge and verdict register.

## Test plan
Bench parameters: DURATION=20, TIMEOUT=5, CHANNELS=2, macro defined unless stated.
- Both channels beat every 3 cycles; start pulse → busy_o high 20 cycles, then done_o=1, pass_o=1, fail_mask_o=00, elapsed_o=20.
- Channel 1 never beats; channel 0 beats every 3 cycles → fail_mask_o=10 six cycles after start; at done, pass_o=0.
- Channel 1 beats exactly on its 5th idle cycle → no fail. err_i[0] pulse at elapsed 10 → fail_mask_o=01 next cycle; pass_o=0.
- abort_i at elapsed 7 → done_o next cycle, elapsed_o=8, pass_o=0. Also abort coincident with elapsed 19 → pass_o=0.
- start_i during RUN is ignored. start_i in DONE after a failed run → fail mask cleared and the new clean run gives pass_o=1.
- rst_n low at elapsed 12 → all outputs 0 immediately, state IDLE. With the macro undefined and no beats → pass_o=1.
